mult_div_seq: RTL and testbench
===============================

# mult_div_seq

Iterative multiply/divide sequencer for the MIPS pipeline's HI/LO unit. It accepts MULT, MULTU, DIV and DIVU operands from the EX stage and runs a radix-2 shift-add or restoring-divide datapath over a fixed number of cycles. It writes the results to the HI/LO registers. While a result is pending it drives a stall request to the hazard logic for any HI/LO access.

## Interface
- No parameters; the data width is fixed at 32.
- Clk  in  1  system clock, rising-edge.
- Rst  in  1  reset; one clock; reset is asynchronous and active-high.
- start  in  1  EX-stage request to begin an operation; sampled on the rising edge.
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  in  32  rs operand (multiplicand or dividend).
- b  in  32  rt operand (multiplier or divisor).
- hilo_rd  in  1  MFHI or MFLO is present in EX.
- wr_hi  in  1  MTHI write, from EX.
- wr_lo  in  1  MTLO write, from EX.
- wdata  in  32  MTHI/MTLO data.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  an operation is in progress.
- done  out  1  one-cycle pulse when HI/LO receive a new result.
- stall  out  1  combinational request to hold IF/ID/EX.

## Operation
- States:
  - IDLE: waiting for an operation.
  - RUN: 32 iterations, counted by a 5-bit down-counter from 31 to 0.
  - FIX: one cycle of sign correction and HI/LO write.
- Transitions:
  - IDLE -> RUN when start=1.
  - RUN -> FIX when the counter is 0 at the clock edge.
  - FIX -> IDLE unconditionally.
- Operand capture on start:
  - Each operand register holds |x| if op[0]=1 and the operand is negative; otherwise it holds the raw operand. The absolute value is taken as an unsigned 32-bit value, so |0x80000000| = 0x80000000.
  - Latch neg_p = a[31]^b[31] and neg_r = a[31]. Both are forced to 0 for unsigned ops.
- Multiply: 64-bit shift-add, one multiplier bit per RUN cycle. In FIX, {hi,lo} = neg_p ? -prod : prod, using 64-bit two's-complement negation.
- Divide: restoring division with a 33-bit partial remainder, one quotient bit per RUN cycle.
  - In FIX: lo = neg_p ? -q : q, and hi = neg_r ? -r : r.
  - The remainder takes the dividend's sign.
- Divide by zero is fully defined and takes the same latency: lo = 0xFFFFFFFF, and hi = a as captured (raw a, not its absolute value).
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. No trap is raised.
- wr_hi and wr_lo while in IDLE: the selected register loads wdata at the clock edge.
- start together with wr_hi or wr_lo in IDLE: start wins and the write is dropped. Decoding guarantees this does not occur.
- stall = busy & (hilo_rd | start | wr_hi | wr_lo).
- When busy=1, start, wr_hi and wr_lo are ignored; the held instruction retries once busy falls.
- Inputs a, b and op are not needed after the capture edge.

## Timing
- Reset values: hi = 0, lo = 0, busy = 0, done = 0, state = IDLE, counter = 0. stall = 0 follows from busy = 0.
- Edge E0: start is sampled and busy rises after E0.
- Edges E1 to E32: RUN iterations.
- Edge E33: FIX writes hi/lo, done=1 for the cycle following E33, and busy=0 after E33.
- Latency is 33 clocks from the start edge to valid hi/lo. It is identical for all ops, including divide by zero.
- A new start is accepted on E33+1 at the earliest, giving back-to-back throughput of one operation per 34 clocks.
- MFHI/MFLO held in EX sees stall=1 through the cycle before E33. In the cycle after E33 it reads the new value, because stall is then 0 and hi/lo are already updated.
- Rst asserted mid-operation (any state):
  - Immediately clears all state and outputs, with no done pulse.
  - The partial result is discarded, and hi/lo return to 0.
- Rst deasserting coincident with a start edge: start is ignored. Start is sampled only on edges where Rst=0.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done on the 33rd edge after start; busy high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start a MULT, then hold hilo_rd=1 and pulse start/wr_hi -> stall=1 every cycle while busy. The second start and wr_hi have no effect, and stall=0 the cycle after done.
- In IDLE: wr_lo=1 with wdata=0x12345678 -> lo=0x12345678 next cycle, with hi unchanged. Next, wr_hi=1 with wdata=0xCAFEF00D -> hi=0xCAFEF00D.
- Start DIVU 1000/7, then assert Rst asynchronously 10 cycles in -> busy, done, hi and lo all go to 0 immediately with no done pulse. After release, DIVU 1000/7 completes with lo=142, hi=6.

Source files
------------

// File: rtl/mult_div_seq.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// 32 RUN iterations plus one FIX cycle for sign correction and the HI/LO write.
module mult_div_seq (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hilo_rd,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic [32:0] acc;
    logic [31:0] sh;
    logic [31:0] opd;
    logic [31:0] raw_a;
    logic        is_div;
    logic        neg_p;
    logic        neg_r;

    logic        sgn_a, sgn_b;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic [63:0] prod, prod_fix;
    logic [31:0] q_fix, r_fix;
    logic        div_zero;

    // Signed ops work on magnitudes; |0x80000000| wraps back to 0x80000000 as unsigned.
    assign sgn_a = op[0] & a[31];
    assign sgn_b = op[0] & b[31];
    assign abs_a = sgn_a ? (~a + 32'd1) : a;
    assign abs_b = sgn_b ? (~b + 32'd1) : b;

    // acc holds the running high product or the partial remainder; sh holds the
    // multiplier/low product or the dividend/quotient.
    assign mul_sum   = {1'b0, acc[31:0]} + (sh[0] ? {1'b0, opd} : 33'd0);
    assign div_shift = {acc[31:0], sh[31]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opd};

    assign prod     = {acc[31:0], sh};
    assign prod_fix = neg_p ? (~prod + 64'd1) : prod;
    assign q_fix    = neg_p ? (~sh + 32'd1) : sh;
    assign r_fix    = neg_r ? (~acc[31:0] + 32'd1) : acc[31:0];
    assign div_zero = (opd == 32'd0);

    assign busy  = (state != IDLE);
    assign stall = busy & (hilo_rd | start | wr_hi | wr_lo);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == 5'd0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt    <= 5'd0;
            acc    <= 33'd0;
            sh     <= 32'd0;
            opd    <= 32'd0;
            raw_a  <= 32'd0;
            is_div <= 1'b0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= 33'd0;
                        cnt    <= 5'd31;
                        raw_a  <= a;
                        is_div <= op[1];
                        neg_p  <= op[0] & (a[31] ^ b[31]);
                        neg_r  <= op[0] & a[31];
                        if (op[1]) begin
                            sh  <= abs_a;
                            opd <= abs_b;
                        end else begin
                            sh  <= abs_b;
                            opd <= abs_a;
                        end
                    end else begin
                        if (wr_hi) hi <= wdata;
                        if (wr_lo) lo <= wdata;
                    end
                end
                RUN: begin
                    cnt <= cnt - 5'd1;
                    if (is_div) begin
                        if (!div_diff[33]) begin
                            acc <= div_diff[32:0];
                            sh  <= {sh[30:0], 1'b1};
                        end else begin
                            acc <= div_shift;
                            sh  <= {sh[30:0], 1'b0};
                        end
                    end else begin
                        acc <= {1'b0, mul_sum[32:1]};
                        sh  <= {mul_sum[0], sh[31:1]};
                    end
                end
                FIX: begin
                    cnt  <= 5'd0;
                    done <= 1'b1;
                    if (!is_div) begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end else if (div_zero) begin
                        // Divide by zero reports the raw dividend, not its magnitude.
                        hi <= raw_a;
                        lo <= 32'hFFFF_FFFF;
                    end else begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq: hand-computed results, latency, stall behaviour,
// direct HI/LO writes and asynchronous reset mid-operation.
module tb_mult_div_seq;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        hilo_rd, wr_hi, wr_lo;
    logic [31:0] wdata;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    int pass_count  = 0;
    int fail_count  = 0;
    int check_count = 0;

    mult_div_seq dut (
        .Clk(Clk), .Rst(Rst), .start(start), .op(op), .a(a), .b(b),
        .hilo_rd(hilo_rd), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Issues a one-cycle start; operands are scrambled afterwards since they are captured at E0.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge Clk);
        #1;
        start = 1'b0;
        op    = ~o;
        a     = 32'hA5A5_5A5A;
        b     = 32'h3C3C_C3C3;
    endtask

    task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int busy_cycles);
        applyStimulus(o, x, y);
        lat = 0;
        busy_cycles = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge Clk);
            #1;
            lat++;
            if (busy) busy_cycles++;
        end
    endtask

    initial begin
        int lat, bc, n, bad, done_seen;

        Rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hilo_rd = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;

        checkOutput("reset_hi", hi, 32'h0);
        checkOutput("reset_lo", lo, 32'h0);
        checkOutput("reset_busy", {31'd0, busy}, 32'h0);
        checkOutput("reset_done", {31'd0, done}, 32'h0);
        checkOutput("reset_stall", {31'd0, stall}, 32'h0);

        runOp(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
        checkOutput("multu_latency", 32'(lat), 32'd33);
        checkOutput("multu_busy_cycles", 32'(bc), 32'd33);
        checkOutput("multu_hi", hi, 32'hFFFF_FFFE);
        checkOutput("multu_lo", lo, 32'h0000_0001);
        @(posedge Clk); #1;
        checkOutput("multu_done_pulse_width", {31'd0, done}, 32'h0);

        runOp(2'b01, 32'hFFFF_FFFD, 32'd5, lat, bc);
        checkOutput("mult_neg_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_neg_lo", lo, 32'hFFFF_FFF1);

        runOp(2'b00, 32'h8000_0000, 32'd2, lat, bc);
        checkOutput("multu_carry_hi", hi, 32'h0000_0001);
        checkOutput("multu_carry_lo", lo, 32'h0000_0000);

        runOp(2'b11, 32'hFFFF_FFF9, 32'd2, lat, bc);
        checkOutput("div_neg_lo", lo, 32'hFFFF_FFFD);
        checkOutput("div_neg_hi", hi, 32'hFFFF_FFFF);

        runOp(2'b10, 32'd100, 32'd0, lat, bc);
        checkOutput("divu_zero_latency", 32'(lat), 32'd33);
        checkOutput("divu_zero_lo", lo, 32'hFFFF_FFFF);
        checkOutput("divu_zero_hi", hi, 32'h0000_0064);

        runOp(2'b11, 32'hFFFF_FFF9, 32'd0, lat, bc);
        checkOutput("div_zero_neg_lo", lo, 32'hFFFF_FFFF);
        checkOutput("div_zero_neg_hi", hi, 32'hFFFF_FFF9);

        runOp(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
        checkOutput("div_overflow_lo", lo, 32'h8000_0000);
        checkOutput("div_overflow_hi", hi, 32'h0000_0000);

        runOp(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, lat, bc);
        checkOutput("divu_big_lo", lo, 32'h0000_0001);
        checkOutput("divu_big_hi", hi, 32'h7FFF_FFFE);

        // MULT 6 * -2 with MFHI held in EX and a stray start/MTHI while busy.
        applyStimulus(2'b01, 32'd6, 32'hFFFF_FFFE);
        hilo_rd = 1'b1;
        n = 0;
        bad = 0;
        while (busy && n < 40) begin
            if (stall !== 1'b1) bad++;
            start = (n == 3);
            wr_hi = (n == 6);
            wdata = 32'h0000_0055;
            op    = 2'b00;
            a     = 32'd7;
            b     = 32'd7;
            @(posedge Clk);
            #1;
            n++;
        end
        start = 1'b0;
        wr_hi = 1'b0;
        checkOutput("stall_busy_cycles", 32'(n), 32'd33);
        checkOutput("stall_missing_cycles", 32'(bad), 32'd0);
        checkOutput("stall_after_done", {31'd0, stall}, 32'h0);
        checkOutput("stall_done", {31'd0, done}, 32'h1);
        checkOutput("stall_mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("stall_mult_lo", lo, 32'hFFFF_FFF4);
        hilo_rd = 1'b0;
        @(posedge Clk); #1;
        checkOutput("ignored_start_busy", {31'd0, busy}, 32'h0);

        wr_lo = 1'b1; wdata = 32'h1234_5678;
        @(posedge Clk); #1;
        wr_lo = 1'b0;
        checkOutput("mtlo_lo", lo, 32'h1234_5678);
        checkOutput("mtlo_hi_unchanged", hi, 32'hFFFF_FFFF);
        wr_hi = 1'b1; wdata = 32'hCAFE_F00D;
        @(posedge Clk); #1;
        wr_hi = 1'b0;
        checkOutput("mthi_hi", hi, 32'hCAFE_F00D);
        checkOutput("mthi_lo_unchanged", lo, 32'h1234_5678);

        applyStimulus(2'b10, 32'd1000, 32'd7);
        repeat (10) begin @(posedge Clk); #1; end
        checkOutput("prereset_busy", {31'd0, busy}, 32'h1);
        hilo_rd = 1'b1;
        #2;
        Rst = 1'b1;
        #1;
        checkOutput("async_reset_busy", {31'd0, busy}, 32'h0);
        checkOutput("async_reset_done", {31'd0, done}, 32'h0);
        checkOutput("async_reset_stall", {31'd0, stall}, 32'h0);
        checkOutput("async_reset_hi", hi, 32'h0);
        checkOutput("async_reset_lo", lo, 32'h0);
        @(posedge Clk); #1;
        Rst = 1'b0;
        hilo_rd = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge Clk); #1;
            if (done) done_seen++;
        end
        checkOutput("reset_no_done_pulse", 32'(done_seen), 32'd0);

        runOp(2'b10, 32'd1000, 32'd7, lat, bc);
        checkOutput("divu_after_reset_latency", 32'(lat), 32'd33);
        checkOutput("divu_after_reset_lo", lo, 32'd142);
        checkOutput("divu_after_reset_hi", hi, 32'd6);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
